uart_transmitter: RTL and testbench

//  Consumer (read) side of the UART transmit FIFO. Pops one character at a time

---
 rtl/uart_transmitter_pkg.sv | 32 +++
 rtl/uart_transmitter.sv | 114 +++++++++++
 tb/tb_uart_transmitter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared constants for the UART transmit path: FIFO widths, LCR bit indices,
// transmitter state encoding and the per-bit tick count.
package uart_transmitter_pkg;

  localparam int UART_FIFO_WIDTH     = 8;
  localparam int UART_FIFO_COUNTER_W = 5;
  localparam int TICKS_PER_BIT       = 16;

  localparam int LCR_STOP = 2;
  localparam int LCR_PE   = 3;
  localparam int LCR_EPS  = 4;
  localparam int LCR_SP   = 5;
  localparam int LCR_BC   = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } tx_state_e;

  // Parity over the sent bits only; stick parity ignores the data entirely.
  function automatic logic par_bit(input logic [7:0] d, input logic [5:0] l);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - l[1:0]);
    if (l[LCR_SP]) return ~l[LCR_EPS];
    return l[LCR_EPS] ? ^(d & mask) : ~^(d & mask);
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// TX FIFO consumer: pops one character and serialises it as start, 5..8 data
// bits LSB first, optional parity and 1 or 2 stop bits on the 16x baud enable.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int fifo_width     = UART_FIFO_WIDTH,
  parameter int fifo_counter_w = UART_FIFO_COUNTER_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [7:0]                lcr,
  input  logic [fifo_counter_w-1:0] tf_count,
  input  logic [fifo_width-1:0]     tf_data_out,
  output logic                      tf_pop,
  output logic                      stx_pad_o,
  output logic                      tx_busy,
  output logic [2:0]                tstate
);

  tx_state_e             state, state_d;
  logic [3:0]            tick_cnt, tick_d;
  logic [2:0]            bit_cnt, bit_d;
  logic [fifo_width-1:0] shreg, shreg_d;
  logic [5:0]            lcr_q, lcr_d;
  logic                  par_q, par_d;
  logic                  pop_d, line_d, stx_d, bit_end;
  logic                  lcr_unused;

  assign lcr_unused = lcr[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      lcr_q     <= '0;
      par_q     <= 1'b0;
      tf_pop    <= 1'b0;
      stx_pad_o <= 1'b1;
    end else begin
      state     <= state_d;
      tick_cnt  <= tick_d;
      bit_cnt   <= bit_d;
      shreg     <= shreg_d;
      lcr_q     <= lcr_d;
      par_q     <= par_d;
      tf_pop    <= pop_d;
      stx_pad_o <= stx_d;
    end
  end

  // Everything is computed from the next state so the registered line level
  // lines up with the registered state (start bit drives low in the START cycle).
  always_comb begin
    state_d = state;
    tick_d  = tick_cnt;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    lcr_d   = lcr_q;
    par_d   = par_q;
    bit_end = enable && (tick_cnt == 4'(TICKS_PER_BIT - 1));

    if (enable && (state inside {S_START, S_DATA, S_PARITY, S_STOP}))
      tick_d = tick_cnt + 4'd1;

    case (state)
      S_IDLE:  if (tf_count != '0) state_d = S_POP;
      S_POP: begin
        state_d = S_START;
        shreg_d = tf_data_out;
        lcr_d   = lcr[5:0];
        par_d   = par_bit(tf_data_out[7:0], lcr[5:0]);
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: if (bit_end) begin
        // last bit index is word length - 1 = lcr[1:0] + 4
        if (bit_cnt == {1'b1, lcr_q[1:0]}) begin
          state_d = lcr_q[LCR_PE] ? S_PARITY : S_STOP;
        end else begin
          shreg_d = shreg >> 1;
          bit_d   = bit_cnt + 3'd1;
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: if (bit_end) begin
        if (lcr_q[LCR_STOP] && bit_cnt == 3'd0) bit_d = 3'd1;
        else state_d = (tf_count != '0) ? S_POP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state) begin
      tick_d = '0;
      bit_d  = '0;
    end

    pop_d = (state_d == S_POP);

    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shreg_d[0];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase

    stx_d = lcr[LCR_BC] ? 1'b0 : line_d;
  end

  assign tstate  = state;
  assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed and randomised frames against a bit-list model of the async frame.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic [7:0] lcr;
  logic [4:0] tf_count;
  logic [7:0] tf_data_out;
  logic       tf_pop, stx_pad_o, tx_busy;
  logic [2:0] tstate;

  uart_transmitter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lcr(lcr),
    .tf_count(tf_count), .tf_data_out(tf_data_out), .tf_pop(tf_pop),
    .stx_pad_o(stx_pad_o), .tx_busy(tx_busy), .tstate(tstate)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  bit         exp_q[$];
  logic       obs_q[$];
  int n_assert = 0, n_fail = 0;
  int pops = 0, idle_full = 0, brk_bad = 0, en_div = 4, en_ph = 0;
  bit brk_watch = 0;
  logic s_pop, s_stx;
  logic [2:0] s_state;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic upd_fifo();
    tf_count    = 5'(fifo_q.size());
    tf_data_out = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    upd_fifo();
  endtask

  // One clock: sample on the falling edge, then act as FIFO and baud source
  // just after the rising edge.
  task automatic cyc();
    logic p;
    @(negedge clk);
    p = tf_pop; s_pop = tf_pop; s_stx = stx_pad_o; s_state = tstate;
    if (tf_pop) pops++;
    if (tstate == 3'd0 && fifo_q.size() != 0) idle_full++;
    if (enable && tstate >= 3'd2 && tstate <= 3'd5) obs_q.push_back(stx_pad_o);
    if (brk_watch && tstate != 3'd0 && stx_pad_o !== 1'b0) brk_bad++;
    @(posedge clk); #1;
    if (p && fifo_q.size() != 0) void'(fifo_q.pop_front());
    upd_fifo();
    en_ph++;
    enable = (en_ph >= en_div);
    if (enable) en_ph = 0;
  endtask

  // Model: one list entry per bit time of the frame.
  task automatic add_frame(input logic [7:0] d, input logic [7:0] l);
    int wl, ones;
    wl = int'(l[1:0]) + 5;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < wl; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (l[3]) begin
      if (l[5])      exp_q.push_back(!l[4]);
      else if (l[4]) exp_q.push_back(ones % 2 == 1);
      else           exp_q.push_back(ones % 2 == 0);
    end
    exp_q.push_back(1'b1);
    if (l[2]) exp_q.push_back(1'b1);
  endtask

  task automatic clear_obs();
    obs_q.delete(); exp_q.delete();
    pops = 0; idle_full = 0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while (!(fifo_q.size() == 0 && tstate == 3'd0) && n < max_cyc) begin
      cyc(); n++;
    end
    chk({tag, "_done"}, n < max_cyc, 1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    int n = 0;
    while (tstate != st && n < 3000) begin cyc(); n++; end
    chk({tag, "_reach"}, tstate, st);
  endtask

  // Each expected bit must appear as exactly 16 identical enable samples.
  task automatic cmp_frames(input string tag);
    logic v;
    chk({tag, "_len"}, obs_q.size(), 16 * exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      v = 1'bx;
      if (16 * i + 15 < obs_q.size()) begin
        v = obs_q[16 * i];
        for (int j = 1; j < 16; j++) if (obs_q[16 * i + j] !== v) v = 1'bx;
      end
      chk($sformatf("%s_bit%0d", tag, i), {31'b0, v}, {31'b0, exp_q[i]});
    end
  endtask

  task automatic run_frames(input string tag, input logic [7:0] l, input logic [7:0] d[$]);
    clear_obs();
    lcr = l;
    foreach (d[i]) begin push(d[i]); add_frame(d[i], l); end
    drain(tag, 3000 * d.size());
    cmp_frames(tag);
    chk({tag, "_pops"}, pops, d.size());
  endtask

  initial begin
    logic [7:0] dq[$];
    logic [7:0] l;
    int k;
    rst_n = 1'b1; enable = 1'b0; lcr = 8'h00;
    upd_fifo();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stx", stx_pad_o, 1);
    chk("rst_pop", tf_pop, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_tstate", tstate, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) cyc();

    // 8N1 0xA5 with first-frame latency
    clear_obs(); lcr = 8'h03; en_div = 4;
    push(8'hA5); add_frame(8'hA5, 8'h03);
    cyc();
    chk("lat_c0_pop", s_pop, 0);
    chk("lat_c0_state", s_state, 0);
    cyc();
    chk("lat_c1_pop", s_pop, 1);
    chk("lat_c1_state", s_state, 1);
    chk("lat_c1_stx", s_stx, 1);
    cyc();
    chk("lat_c2_pop", s_pop, 0);
    chk("lat_c2_stx", s_stx, 0);
    chk("lat_c2_state", s_state, 2);
    drain("f8n1", 3000);
    cmp_frames("f8n1");
    chk("f8n1_pops", pops, 1);
    chk("f8n1_busy", tx_busy, 0);

    // parity variants on 0x07
    dq = '{8'h07};
    run_frames("even", 8'h1B, dq);
    run_frames("odd", 8'h0B, dq);
    run_frames("stick", 8'h2B, dq);

    // 5 data bits, 2 stop bits
    dq = '{8'hFF};
    run_frames("w5s2", 8'h04, dq);

    // three characters back to back
    dq = '{8'h3C, 8'h81, 8'h5E};
    en_div = 2;
    run_frames("b2b", 8'h03, dq);
    chk("b2b_idle_gap", idle_full, 1);
    chk("b2b_count", tf_count, 0);

    // asynchronous reset mid-DATA
    clear_obs(); lcr = 8'h03; push(8'h00);
    wait_state("rst_mid", 3'd3);
    repeat (3) cyc();
    chk("rst_mid_pre_stx", stx_pad_o, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_stx", stx_pad_o, 1);
    chk("rst_mid_tstate", tstate, 0);
    chk("rst_mid_busy", tx_busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    pops = 0;
    repeat (100) cyc();
    chk("rst_mid_nopop", pops, 0);
    chk("rst_mid_idle_stx", stx_pad_o, 1);

    // break during DATA
    clear_obs(); en_div = 1; lcr = 8'h03;
    push(8'hFF); add_frame(8'hFF, 8'h03);
    wait_state("brk", 3'd3);
    lcr = 8'h43;
    cyc();
    brk_watch = 1; brk_bad = 0;
    drain("brk", 3000);
    brk_watch = 0;
    chk("brk_line_low", brk_bad, 0);
    chk("brk_frame_len", obs_q.size(), 16 * exp_q.size());
    chk("brk_busy", tx_busy, 0);
    chk("brk_held_stx", stx_pad_o, 0);
    lcr = 8'h03;
    cyc();
    chk("brk_release_stx", stx_pad_o, 1);

    // random frames; single-character batches also change lcr mid-frame
    for (int b = 0; b < 12; b++) begin
      en_div = $urandom_range(1, 4);
      l = 8'($urandom_range(0, 63));
      k = $urandom_range(1, 3);
      dq.delete();
      for (int i = 0; i < k; i++) dq.push_back(8'($urandom));
      if (k > 1) run_frames($sformatf("rnd%0d", b), l, dq);
      else begin
        clear_obs(); lcr = l;
        push(dq[0]); add_frame(dq[0], l);
        repeat ($urandom_range(3, 40)) cyc();
        lcr = 8'($urandom_range(0, 63));
        drain($sformatf("rnd%0d", b), 3000);
        cmp_frames($sformatf("rnd%0d", b));
        chk($sformatf("rnd%0d_pops", b), pops, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
